axi_decerr_slave: RTL and testbench
===================================

AXI_DECERR_SLAVE -- requirements
Module: axi_decerr_slave

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 5, AXI ID width (crossbar slave-side ID width).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, AXI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, R data width.
REQ-004 SHALL have ports:
clk_i  in  1  sole clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
aw_valid_i / aw_ready_o  in/out  1  AW handshake
aw_id_i  in  ID_WIDTH  write ID
aw_addr_i  in  ADDR_WIDTH  write address
w_valid_i / w_ready_o  in/out  1  W handshake
w_last_i  in  1  last write beat
b_valid_o / b_ready_i  out/in  1  B handshake
b_id_o  out  ID_WIDTH  write response ID
b_resp_o  out  2  write response
ar_valid_i / ar_ready_o  in/out  1  AR handshake
ar_id_i  in  ID_WIDTH  read ID
ar_addr_i  in  ADDR_WIDTH  read address
ar_len_i  in  8  burst length minus one
r_valid_o / r_ready_i  out/in  1  R handshake
r_id_o  out  ID_WIDTH  read ID
r_data_o  out  DATA_WIDTH  read data
r_resp_o  out  2  read response
r_last_o  out  1  last read beat
err_valid_o  out  1  error log valid (AXI_DECERR_LOG_EN only)
err_write_o  out  1  logged access was a write (AXI_DECERR_LOG_EN only)
err_addr_o  out  ADDR_WIDTH  logged faulting address (AXI_DECERR_LOG_EN only)
err_clear_i  in  1  clear error log (AXI_DECERR_LOG_EN only)

Function
REQ-005 SHALL answer every transaction with DECERR (2'b11) on b_resp_o and r_resp_o; r_data_o SHALL be all-zero.
REQ-006 Write FSM states W_IDLE, W_DATA, W_RESP; read FSM states R_IDLE, R_DATA; the two FSMs SHALL operate independently and concurrently.
REQ-007 W_IDLE: aw_ready_o=1; on aw_valid_i capture aw_id_i, go W_DATA next cycle.
REQ-008 W_DATA: w_ready_o=1, aw_ready_o=0; discard data; on w_valid_i&&w_last_i go W_RESP.
REQ-009 W_RESP: b_valid_o=1, b_id_o=captured ID; on b_ready_i go W_IDLE; b_valid_o SHALL stay high until accepted.
REQ-010 Minimum write latency: AW accept cycle N, single W beat cycle N+1, b_valid_o asserted cycle N+2.
REQ-011 W beats presented before AW acceptance SHALL NOT be accepted (w_ready_o=0 outside W_DATA).
REQ-012 R_IDLE: ar_ready_o=1; on ar_valid_i capture ar_id_i, load 8-bit beat counter with ar_len_i, go R_DATA.
REQ-013 R_DATA: r_valid_o=1, ar_ready_o=0; each r_valid_o&&r_ready_i decrements counter; r_last_o=1 iff counter==0; handshake with r_last_o returns to R_IDLE.
REQ-014 ar_len_i=255 SHALL yield exactly 256 beats, no counter wrap; ar_len_i=0 yields one beat with r_last_o=1.
REQ-015 r_valid_o, r_id_o, r_last_o SHALL be stable while r_valid_o&&!r_ready_i.
REQ-016 One outstanding write and one outstanding read at most; no further AW/AR accepted until its response completes.

Reset
REQ-017 rst_i asserted SHALL immediately force W_IDLE, R_IDLE, counter=0, captured IDs=0, err_valid_o=0, err_write_o=0, err_addr_o=0.
REQ-018 During reset aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o SHALL be 0; b_resp_o/r_resp_o SHALL read 2'b11.
REQ-019 Reset mid-burst SHALL abandon the transaction without emitting remaining beats; first cycle after deassert shows idle readiness.

Configuration
REQ-020 Macro AXI_DECERR_LOG_EN: when defined, first faulting access after reset/clear SHALL be logged (err_valid_o=1, err_addr_o, err_write_o) the cycle after AW/AR acceptance; later faults SHALL NOT overwrite it until err_clear_i.
REQ-021 With simultaneous AW and AR acceptance while log empty, the write SHALL be logged; err_clear_i coincident with a new fault SHALL log the new fault.
REQ-022 Without AXI_DECERR_LOG_EN, err_* outputs SHALL be tied to 0, err_clear_i ignored, no log registers instantiated.

Verification
REQ-023 AW id=5 addr=0x4000_0000, one W beat last=1, b_ready=1 -> b_valid cycle N+2, b_id=5, b_resp=2'b11.
REQ-024 AR id=3 len=3, r_ready=1 -> four R beats, r_id=3, r_resp=2'b11, data=0, r_last only on fourth.
REQ-025 AR len=255 with r_ready toggling every cycle -> exactly 256 beats, stable outputs when stalled, then ar_ready=1.
REQ-026 AW+AR same cycle, W 2 beats, both responses -> both complete independently; log (if enabled) shows write address, err_write=1.
REQ-027 rst_i asserted during beat 2 of a len=7 read -> r_valid=0 immediately, ar_ready=1 the cycle after release.
REQ-028 Log enabled: fault at 0x1_0000, then fault at 0x2_0000 -> err_addr stays 0x1_0000; pulse err_clear -> err_valid=0.

Source files
------------

// File: rtl/axi_decerr_slave.sv
// AXI default slave: answers every write and read with DECERR and all-zero data.
// Optional first-fault log is built only when AXI_DECERR_LOG_EN is defined.
module axi_decerr_slave #(
    parameter int ID_WIDTH   = 5,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  logic [ADDR_WIDTH-1:0] aw_addr_i,

    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic                  w_last_i,

    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,

    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]            ar_len_i,

    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,

    output logic                  err_valid_o,
    output logic                  err_write_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    input  logic                  err_clear_i
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    w_state_e            w_state_q, w_state_d;
    logic [ID_WIDTH-1:0] b_id_q, b_id_d;
    r_state_e            r_state_q, r_state_d;
    logic [ID_WIDTH-1:0] r_id_q, r_id_d;
    logic [7:0]          cnt_q, cnt_d;

    logic aw_hs;
    logic ar_hs;

    // Readiness is masked by reset so nothing is accepted while rst_i is high.
    assign aw_ready_o = (w_state_q == W_IDLE) & ~rst_i;
    assign w_ready_o  = (w_state_q == W_DATA);
    assign b_valid_o  = (w_state_q == W_RESP);
    assign b_id_o     = b_id_q;
    assign b_resp_o   = RESP_DECERR;

    assign ar_ready_o = (r_state_q == R_IDLE) & ~rst_i;
    assign r_valid_o  = (r_state_q == R_DATA);
    assign r_last_o   = (r_state_q == R_DATA) && (cnt_q == 8'd0);
    assign r_id_o     = r_id_q;
    assign r_data_o   = '0;
    assign r_resp_o   = RESP_DECERR;

    assign aw_hs = aw_valid_i & aw_ready_o;
    assign ar_hs = ar_valid_i & ar_ready_o;

    always_comb begin
        w_state_d = w_state_q;
        b_id_d    = b_id_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_valid_i) begin
                    b_id_d    = aw_id_i;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_valid_i && w_last_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Counter holds beats remaining after the current one; len=255 gives 256 beats.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        cnt_d     = cnt_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_valid_i) begin
                    r_id_d    = ar_id_i;
                    cnt_d     = ar_len_i;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_ready_i) begin
                    if (cnt_q == 8'd0) begin
                        r_state_d = R_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
            b_id_q    <= '0;
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            cnt_q     <= 8'd0;
        end else begin
            w_state_q <= w_state_d;
            b_id_q    <= b_id_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef AXI_DECERR_LOG_EN
    logic                  err_valid_q, err_valid_d;
    logic                  err_write_q, err_write_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    // A clear in the same cycle as a new fault leaves the new fault logged;
    // a write wins over a simultaneous read.
    always_comb begin
        err_valid_d = err_valid_q;
        err_write_d = err_write_q;
        err_addr_d  = err_addr_q;
        if (err_clear_i) begin
            err_valid_d = 1'b0;
        end
        if (!err_valid_q || err_clear_i) begin
            if (aw_hs) begin
                err_valid_d = 1'b1;
                err_write_d = 1'b1;
                err_addr_d  = aw_addr_i;
            end else if (ar_hs) begin
                err_valid_d = 1'b1;
                err_write_d = 1'b0;
                err_addr_d  = ar_addr_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_valid_q <= 1'b0;
            err_write_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= err_valid_d;
            err_write_q <= err_write_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_write_o = err_write_q;
    assign err_addr_o  = err_addr_q;
`else
    logic unused_inputs;

    assign unused_inputs = ^{err_clear_i, aw_addr_i, ar_addr_i, aw_hs, ar_hs};
    assign err_valid_o   = 1'b0;
    assign err_write_o   = 1'b0;
    assign err_addr_o    = '0;
`endif

endmodule

// File: tb/tb_axi_decerr_slave.sv
// Self-checking bench for axi_decerr_slave: directed and randomized AXI traffic
// checked against a transaction-level expectation of DECERR responses and the fault log.
module tb_axi_decerr_slave;

    localparam int IDW = 5;
    localparam int AW  = 64;
    localparam int DW  = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           aw_valid = 1'b0, aw_ready;
    logic [IDW-1:0] aw_id = '0;
    logic [AW-1:0]  aw_addr = '0;
    logic           w_valid = 1'b0, w_ready, w_last = 1'b0;
    logic           b_valid, b_ready = 1'b0;
    logic [IDW-1:0] b_id;
    logic [1:0]     b_resp;
    logic           ar_valid = 1'b0, ar_ready;
    logic [IDW-1:0] ar_id = '0;
    logic [AW-1:0]  ar_addr = '0;
    logic [7:0]     ar_len = '0;
    logic           r_valid, r_ready = 1'b0;
    logic [IDW-1:0] r_id;
    logic [DW-1:0]  r_data;
    logic [1:0]     r_resp;
    logic           r_last;
    logic           err_valid, err_write;
    logic [AW-1:0]  err_addr;
    logic           err_clear = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Expected first-fault log: first accepted address after reset or clear.
    logic          m_lv = 1'b0;
    logic          m_lw = 1'b0;
    logic [AW-1:0] m_la = '0;

    always #5 clk = ~clk;

    axi_decerr_slave #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id), .ar_addr_i(ar_addr),
        .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .err_valid_o(err_valid), .err_write_o(err_write), .err_addr_o(err_addr),
        .err_clear_i(err_clear)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lv <= 1'b0;
            m_lw <= 1'b0;
            m_la <= '0;
        end else if (err_clear || !m_lv) begin
            if (aw_valid && aw_ready) begin
                m_lv <= 1'b1; m_lw <= 1'b1; m_la <= aw_addr;
            end else if (ar_valid && ar_ready) begin
                m_lv <= 1'b1; m_lw <= 1'b0; m_la <= ar_addr;
            end else begin
                m_lv <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log();
`ifdef AXI_DECERR_LOG_EN
        chk("err_valid", {63'd0, err_valid}, {63'd0, m_lv});
        if (m_lv) begin
            chk("err_write", {63'd0, err_write}, {63'd0, m_lw});
            chk("err_addr", err_addr, m_la);
        end
`else
        chk("err_valid_tied", {63'd0, err_valid}, 64'd0);
        chk("err_write_tied", {63'd0, err_write}, 64'd0);
        chk("err_addr_tied", err_addr, 64'd0);
`endif
    endtask

    task automatic pulse_clear();
        @(negedge clk); err_clear = 1'b1;
        @(negedge clk); err_clear = 1'b0;
        chk("err_cleared", {63'd0, err_valid}, 64'd0);
    endtask

    // One write: AW, nbeats W beats (optional idle gaps), B held for bstall cycles.
    task automatic do_write(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                            input int nbeats, input int bstall, input bit gaps, input bit clr);
        int t;
        @(negedge clk);
        aw_valid = 1'b1; aw_id = id; aw_addr = addr;
        if (clr) err_clear = 1'b1;
        t = 0;
        while (!aw_ready && t < 50) begin @(negedge clk); t++; end
        chk("aw_ready_idle", {63'd0, aw_ready}, 64'd1);
        @(negedge clk);
        aw_valid = 1'b0; err_clear = 1'b0;
        chk("aw_ready_busy", {63'd0, aw_ready}, 64'd0);
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                w_valid = 1'b0;
                chk("w_ready_gap", {63'd0, w_ready}, 64'd1);
                chk("b_valid_gap", {63'd0, b_valid}, 64'd0);
                @(negedge clk);
            end
            w_valid = 1'b1; w_last = (b == nbeats - 1);
            chk("w_ready", {63'd0, w_ready}, 64'd1);
            chk("b_valid_early", {63'd0, b_valid}, 64'd0);
            @(negedge clk);
        end
        w_valid = 1'b0; w_last = 1'b0;
        for (int s = 0; s <= bstall; s++) begin
            b_ready = (s == bstall);
            chk("b_valid", {63'd0, b_valid}, 64'd1);
            chk("b_id", {59'd0, b_id}, {59'd0, id});
            chk("b_resp", {62'd0, b_resp}, 64'd3);
            chk("w_ready_resp", {63'd0, w_ready}, 64'd0);
            @(negedge clk);
        end
        b_ready = 1'b0;
        chk("b_valid_done", {63'd0, b_valid}, 64'd0);
        chk("aw_ready_done", {63'd0, aw_ready}, 64'd1);
    endtask

    // One read burst of len+1 beats; mode 0 ready always, 1 toggling, 2 random.
    task automatic do_read(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input int mode);
        int  t;
        int  beats;
        logic rdy;
        @(negedge clk);
        ar_valid = 1'b1; ar_id = id; ar_addr = addr; ar_len = 8'(len);
        t = 0;
        while (!ar_ready && t < 50) begin @(negedge clk); t++; end
        chk("ar_ready_idle", {63'd0, ar_ready}, 64'd1);
        @(negedge clk);
        ar_valid = 1'b0;
        beats = 0; t = 0;
        while (beats <= len && t < 4000) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = t[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            r_ready = rdy;
            chk("r_valid", {63'd0, r_valid}, 64'd1);
            chk("r_id", {59'd0, r_id}, {59'd0, id});
            chk("r_resp", {62'd0, r_resp}, 64'd3);
            chk("r_data", r_data, 64'd0);
            chk("r_last", {63'd0, r_last}, {63'd0, (beats == len)});
            chk("ar_ready_busy", {63'd0, ar_ready}, 64'd0);
            if (rdy) beats++;
            @(negedge clk);
            t++;
        end
        r_ready = 1'b0;
        chk("r_beats", 64'(beats), 64'(len + 1));
        chk("r_valid_done", {63'd0, r_valid}, 64'd0);
        chk("ar_ready_done", {63'd0, ar_ready}, 64'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int            kind;
        int            len;
        int            nb;
        int            bs;
        logic [IDW-1:0] rid;
        logic [AW-1:0]  raddr;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_aw_ready", {63'd0, aw_ready}, 64'd0);
        chk("rst_ar_ready", {63'd0, ar_ready}, 64'd0);
        chk("rst_w_ready", {63'd0, w_ready}, 64'd0);
        chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
        chk("rst_r_valid", {63'd0, r_valid}, 64'd0);
        chk("rst_r_last", {63'd0, r_last}, 64'd0);
        chk("rst_b_resp", {62'd0, b_resp}, 64'd3);
        chk("rst_r_resp", {62'd0, r_resp}, 64'd3);
        chk("rst_err_valid", {63'd0, err_valid}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_aw_ready", {63'd0, aw_ready}, 64'd1);
        chk("idle_ar_ready", {63'd0, ar_ready}, 64'd1);

        // W beat before any AW must not be taken
        w_valid = 1'b1; w_last = 1'b1;
        chk("early_w_ready", {63'd0, w_ready}, 64'd0);
        @(negedge clk);
        chk("early_w_ready2", {63'd0, w_ready}, 64'd0);
        chk("early_b_valid", {63'd0, b_valid}, 64'd0);
        w_valid = 1'b0; w_last = 1'b0;

        // Minimum-latency write, then reads of len 3 and 255
        do_write(5'd5, 64'h4000_0000, 1, 0, 1'b0, 1'b0);
        check_log();
        do_write(5'd9, 64'h4000_1000, 1, 2, 1'b0, 1'b0);
        do_read(5'd3, 64'h8000, 3, 0);
        do_read(5'd17, 64'h9000, 255, 1);
        do_read(5'd1, 64'hA000, 0, 0);

        // Simultaneous AW and AR on an empty log: write is logged
        pulse_clear();
        fork
            do_write(5'd12, 64'hCAFE_0000, 2, 1, 1'b0, 1'b0);
            do_read(5'd21, 64'hBEEF_0000, 4, 2);
        join
        check_log();
`ifdef AXI_DECERR_LOG_EN
        chk("log_write_wins", {63'd0, err_write}, 64'd1);
        chk("log_write_addr", err_addr, 64'hCAFE_0000);
`endif

        // First fault sticks until cleared
        pulse_clear();
        do_write(5'd2, 64'h1_0000, 1, 0, 1'b0, 1'b0);
        check_log();
        do_read(5'd4, 64'h2_0000, 0, 0);
        check_log();
`ifdef AXI_DECERR_LOG_EN
        chk("log_hold_addr", err_addr, 64'h1_0000);
`endif
        pulse_clear();

        // Clear coincident with a new fault logs the new fault
        do_read(5'd6, 64'h5_0000, 1, 0);
        do_write(5'd7, 64'h3_0000, 1, 0, 1'b0, 1'b1);
        check_log();
`ifdef AXI_DECERR_LOG_EN
        chk("log_clear_new", err_addr, 64'h3_0000);
`endif

        // Reset during beat 2 of a len=7 read
        @(negedge clk);
        ar_valid = 1'b1; ar_id = 5'd6; ar_len = 8'd7; ar_addr = 64'h7000;
        @(negedge clk);
        ar_valid = 1'b0; r_ready = 1'b1;
        @(negedge clk);
        chk("mid_r_valid", {63'd0, r_valid}, 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_r_valid", {63'd0, r_valid}, 64'd0);
        chk("arst_r_last", {63'd0, r_last}, 64'd0);
        chk("arst_ar_ready", {63'd0, ar_ready}, 64'd0);
        chk("arst_aw_ready", {63'd0, aw_ready}, 64'd0);
        chk("arst_err_valid", {63'd0, err_valid}, 64'd0);
        r_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ar_ready", {63'd0, ar_ready}, 64'd1);
        chk("post_rst_r_valid", {63'd0, r_valid}, 64'd0);
        chk("post_rst_aw_ready", {63'd0, aw_ready}, 64'd1);
        do_read(5'd8, 64'h7100, 0, 0);

        // Randomized mix of writes, reads and concurrent pairs
        for (int i = 0; i < 14; i++) begin
            kind  = $urandom_range(0, 2);
            rid   = IDW'($urandom);
            raddr = {$urandom, $urandom};
            len   = $urandom_range(0, 15);
            nb    = $urandom_range(1, 4);
            bs    = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) pulse_clear();
            case (kind)
                0: do_write(rid, raddr, nb, bs, 1'b1, 1'b0);
                1: do_read(rid, raddr, len, 2);
                default: begin
                    fork
                        do_write(rid, raddr, nb, bs, 1'b1, 1'b0);
                        do_read(~rid, ~raddr, len, 2);
                    join
                end
            endcase
            check_log();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
